// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl_pkg: opcode encodings shared with the ALU and its benches,
// plus the controller FSM state encoding.
package acc_ctrl_pkg;

  localparam logic [2:0] OP_PASS0 = 3'd0;
  localparam logic [2:0] OP_PASS1 = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_PASS6 = 3'd6;
  localparam logic [2:0] OP_PASS7 = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/acc_ctrl.sv
// acc_ctrl: accumulator controller in front of a combinational ALU.
// Commands arrive on a valid/ready handshake, the ALU operands are driven
// from registers only, and the ALU result is written back into the
// accumulator and returned on a second valid/ready handshake.
// Optional feature: define ACC_CTRL_SKZ_EN to compile in skip-if-zero
// (an opcode-7 command seen with a zero accumulator discards the next command).
module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_a_is_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_a_zero,
  output logic             res_skipped,
  output logic [WIDTH-1:0] acc
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             res_a_zero_q;
  logic             accept;
  logic             skip_pending;

`ifdef ACC_CTRL_SKZ_EN
  logic             skip_q;
  logic             res_skipped_q;

  assign skip_pending = skip_q;
  assign res_skipped  = res_skipped_q;
`else
  assign skip_pending = 1'b0;
  assign res_skipped  = 1'b0;
`endif

  // Handshake and ALU-facing outputs are pure functions of registered state.
  assign accept     = (state_q == IDLE) && cmd_valid;
  assign cmd_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign res_data   = acc_q;
  assign res_a_zero = res_a_zero_q;
  assign acc        = acc_q;
  assign alu_opcode = op_q;
  assign alu_in_a   = acc_q;
  assign alu_in_b   = b_q;

  // Next-state logic: a pending skip bypasses EXEC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = skip_pending ? DONE : EXEC;
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch on accept; accumulator and zero flag update only in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_PASS0;
      b_q          <= '0;
      acc_q        <= '0;
      res_a_zero_q <= 1'b0;
    end else if (accept) begin
      op_q <= cmd_opcode;
      b_q  <= cmd_data;
      if (skip_pending) begin
        res_a_zero_q <= 1'b0;
      end
    end else if (state_q == EXEC) begin
      acc_q        <= alu_out;
      res_a_zero_q <= alu_a_is_zero;
    end
  end

`ifdef ACC_CTRL_SKZ_EN
  // Skip flag: armed by opcode 7 on a zero accumulator, consumed by the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q        <= 1'b0;
      res_skipped_q <= 1'b0;
    end else if (accept && skip_q) begin
      skip_q        <= 1'b0;
      res_skipped_q <= 1'b1;
    end else if (state_q == EXEC) begin
      res_skipped_q <= 1'b0;
      if ((op_q == OP_PASS7) && alu_a_is_zero) begin
        skip_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: directed bench for acc_ctrl with a behavioural ALU beside it.
// Define ACC_CTRL_SKZ_EN for both files to exercise skip-if-zero.
module tb_acc_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode = 3'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [2:0]       alu_opcode;
  logic [WIDTH-1:0] alu_in_a;
  logic [WIDTH-1:0] alu_in_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_a_is_zero;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [WIDTH-1:0] res_data;
  logic             res_a_zero;
  logic             res_skipped;
  logic [WIDTH-1:0] acc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acc_ctrl #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opcode    (cmd_opcode),
    .cmd_data      (cmd_data),
    .alu_opcode    (alu_opcode),
    .alu_in_a      (alu_in_a),
    .alu_in_b      (alu_in_b),
    .alu_out       (alu_out),
    .alu_a_is_zero (alu_a_is_zero),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_a_zero    (res_a_zero),
    .res_skipped   (res_skipped),
    .acc           (acc)
  );

  // Behavioural model of the external combinational ALU.
  always_comb begin
    case (alu_opcode)
      3'd2:    alu_out = alu_in_a + alu_in_b;
      3'd3:    alu_out = alu_in_a & alu_in_b;
      3'd4:    alu_out = alu_in_a ^ alu_in_b;
      3'd5:    alu_out = alu_in_b;
      default: alu_out = alu_in_a;
    endcase
    alu_a_is_zero = (alu_in_a == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and wait (bounded) for res_valid; lat counts edges from accept.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] data, output int lat);
    @(negedge clk);
    check("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_data   = data;
    @(posedge clk);
    lat = 1;
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    while (!res_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] data,
                     input logic [WIDTH-1:0] exp_data, input logic exp_az,
                     input logic exp_skip, input int exp_lat);
    int lat;
    issue(op, data, lat);
    check({tag, "_lat"},  32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(res_data), 32'(exp_data));
    check({tag, "_az"},   32'(res_a_zero), 32'(exp_az));
    check({tag, "_skip"}, 32'(res_skipped), 32'(exp_skip));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rv0"},  32'(res_valid), 32'd0);
  endtask

  initial begin
    int lat;
    // Reset state
    #12;
    check("rst_acc",       32'(acc), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data), 32'h0);
    check("rst_res_az",    32'(res_a_zero), 32'd0);
    check("rst_res_skip",  32'(res_skipped), 32'd0);
    check("rst_alu_op",    32'(alu_opcode), 32'd0);
    check("rst_alu_b",     32'(alu_in_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operations
    run("passb42", 3'd5, 8'h42, 8'h42, 1'b1, 1'b0, 2);
    run("add86",   3'd2, 8'h86, 8'hC8, 1'b0, 1'b0, 2);
    run("and86",   3'd3, 8'h86, 8'h80, 1'b0, 1'b0, 2);
    run("xor86",   3'd4, 8'h86, 8'h06, 1'b0, 1'b0, 2);
    run("passbC8", 3'd5, 8'hC8, 8'hC8, 1'b0, 1'b0, 2);
    run("addwrap", 3'd2, 8'h40, 8'h08, 1'b0, 1'b0, 2);
    run("pass0",   3'd0, 8'hFF, 8'h08, 1'b0, 1'b0, 2);
    run("pass1",   3'd1, 8'h77, 8'h08, 1'b0, 1'b0, 2);
    run("pass6",   3'd6, 8'h99, 8'h08, 1'b0, 1'b0, 2);
    check("alu_op_last", 32'(alu_opcode), 32'd6);
    check("alu_b_last",  32'(alu_in_b), 32'h99);

    // Backpressure: result held while res_ready is low, stray command ignored
    res_ready = 1'b0;
    issue(3'd2, 8'h01, lat);
    check("bp_lat",  32'(lat), 32'd2);
    check("bp_data", 32'(res_data), 32'h09);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_valid  = 1'b1;
        cmd_opcode = 3'd5;
        cmd_data   = 8'hFF;
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_hold_data",  32'(res_data), 32'h09);
      check("bp_hold_ready", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_idle", 32'(cmd_ready), 32'd1);
    check("bp_release_rv",   32'(res_valid), 32'd0);
    check("bp_acc_kept",     32'(acc), 32'h09);
    check("bp_b_kept",       32'(alu_in_b), 32'h01);

`ifdef ACC_CTRL_SKZ_EN
    // Skip-if-zero
    run("skz_zero", 3'd5, 8'h00, 8'h00, 1'b0, 1'b0, 2);
    run("skz_op7",  3'd7, 8'h33, 8'h00, 1'b1, 1'b0, 2);
    run("skz_skip", 3'd2, 8'h05, 8'h00, 1'b0, 1'b1, 1);
    run("skz_next", 3'd2, 8'h05, 8'h05, 1'b1, 1'b0, 2);
`else
    // Opcode 7 on a zero accumulator is a plain pass A
    run("op7_zero", 3'd5, 8'h00, 8'h00, 1'b0, 1'b0, 2);
    run("op7_pass", 3'd7, 8'h33, 8'h00, 1'b1, 1'b0, 2);
    run("op7_next", 3'd2, 8'h05, 8'h05, 1'b1, 1'b0, 2);
`endif

    // Reset asserted during EXEC of an ADD
    run("rst_setup", 3'd5, 8'h42, 8'h42, 1'b0, 1'b0, 2);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = 3'd2;
    cmd_data   = 8'h10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("mid_in_exec", 32'(cmd_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_acc",       32'(acc), 32'h0);
    check("mid_res_valid", 32'(res_valid), 32'd0);
    check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_res_data",  32'(res_data), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rv",  32'(res_valid), 32'd0);
      check("post_rst_acc", 32'(acc), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
